// File: rtl/sram_uart_dump_pkg.sv
// Shared definitions for the SRAM-to-UART dump path.
package sram_uart_dump_pkg;

    // Default clock cycles per UART bit (50 MHz / 115200); the receiver uses the same value.
    localparam int unsigned UART_BAUD_DIV = 434;

    typedef enum logic [2:0] {
        S_DUMP_IDLE,
        S_DUMP_ADDR,
        S_DUMP_WAIT1,
        S_DUMP_WAIT2,
        S_DUMP_TX_HI,
        S_DUMP_TX_LO,
        S_DUMP_DONE
    } dump_state_type;

    // Sub-steps inside the two byte-transmit states.
    typedef enum logic [1:0] {
        TX_ISSUE,
        TX_WAIT,
        TX_ADVANCE
    } tx_phase_type;

endpackage

// File: rtl/sram_uart_dump_uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
import sram_uart_dump_pkg::*;

module uart_tx_byte #(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV
) (
    input  logic       Clock_50,
    input  logic       Resetn,
    input  logic       Tx_start,
    input  logic [7:0] Tx_data,
    output logic       UART_TX_O,
    output logic       Tx_busy
);

    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);

    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_active;
    logic          r_busy;
    logic          r_tx;

    assign UART_TX_O = r_tx;
    assign Tx_busy   = r_busy;

    // Frame sequencing; busy drops one cycle early so the next byte can follow with a 1-cycle gap.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
            r_active <= 1'b0;
            r_busy   <= 1'b0;
            r_tx     <= 1'b1;
        end else if (Tx_start && !r_busy) begin
            r_tx     <= 1'b0;
            r_shift  <= {1'b1, Tx_data};
            r_bit    <= '0;
            r_baud   <= '0;
            r_active <= 1'b1;
            r_busy   <= 1'b1;
        end else if (r_active) begin
            if (r_baud == BAUD_LAST) begin
                r_baud <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_bit == 4'd9 && r_baud == BAUD_PRE) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram_uart_dump.sv
// Reads a block of 16-bit SRAM words and sends each one high byte first over the UART.
import sram_uart_dump_pkg::*;

module sram_uart_dump #(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV,
    parameter int unsigned ADDR_W   = 18
) (
    input  logic              Clock_50,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_address,
    input  logic [ADDR_W-1:0] Word_count,
    output logic [ADDR_W-1:0] SRAM_address,
    input  logic [15:0]       SRAM_read_data,
    output logic              SRAM_we_n,
    output logic              UART_TX_O,
    output logic              Busy,
    output logic              Done
);

    dump_state_type    r_state;
    tx_phase_type      r_phase;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [ADDR_W-1:0] r_remaining;
    logic [15:0]       r_word_buf;
    logic              r_busy;
    logic              r_done;

    logic              w_tx_start;
    logic [7:0]        w_tx_data;
    logic              w_tx_busy;

    assign SRAM_we_n = 1'b1;
    assign Busy      = r_busy;
    assign Done      = r_done;

    // The address is presented in the ADDR cycle itself and held afterwards, so it only moves there.
    assign SRAM_address = (r_state == S_DUMP_ADDR) ? r_addr : r_addr_hold;

    assign w_tx_start = ((r_state == S_DUMP_TX_HI) || (r_state == S_DUMP_TX_LO))
                        && (r_phase == TX_ISSUE);
    assign w_tx_data  = (r_state == S_DUMP_TX_HI) ? r_word_buf[15:8] : r_word_buf[7:0];

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .Clock_50  (Clock_50),
        .Resetn    (Resetn),
        .Tx_start  (w_tx_start),
        .Tx_data   (w_tx_data),
        .UART_TX_O (UART_TX_O),
        .Tx_busy   (w_tx_busy)
    );

    // Dump sequencer: fetch a word, send two bytes, step address/count, repeat until count is spent.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= S_DUMP_IDLE;
            r_phase     <= TX_ISSUE;
            r_addr      <= '0;
            r_addr_hold <= '0;
            r_remaining <= '0;
            r_word_buf  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_DUMP_IDLE: begin
                    if (Start) begin
                        r_addr      <= Base_address;
                        r_remaining <= Word_count;
                        if (Word_count == '0) begin
                            r_state <= S_DUMP_DONE;
                        end else begin
                            r_state <= S_DUMP_ADDR;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_DUMP_ADDR: begin
                    r_addr_hold <= r_addr;
                    r_state     <= S_DUMP_WAIT1;
                end
                S_DUMP_WAIT1: begin
                    r_state <= S_DUMP_WAIT2;
                end
                S_DUMP_WAIT2: begin
                    r_word_buf <= SRAM_read_data;
                    r_phase    <= TX_ISSUE;
                    r_state    <= S_DUMP_TX_HI;
                end
                S_DUMP_TX_HI: begin
                    if (r_phase == TX_ISSUE) begin
                        r_phase <= TX_WAIT;
                    end else if (!w_tx_busy) begin
                        r_phase <= TX_ISSUE;
                        r_state <= S_DUMP_TX_LO;
                    end
                end
                S_DUMP_TX_LO: begin
                    // The last word exits straight to DONE; other words spend one TX_ADVANCE
                    // cycle so the word period stays at 20*BAUD_DIV+6 cycles.
                    case (r_phase)
                        TX_ISSUE: r_phase <= TX_WAIT;
                        TX_WAIT: begin
                            if (!w_tx_busy) begin
                                r_remaining <= r_remaining - 1'b1;
                                r_addr      <= r_addr + 1'b1;
                                if (r_remaining == ADDR_W'(1)) begin
                                    r_phase <= TX_ISSUE;
                                    r_state <= S_DUMP_DONE;
                                end else begin
                                    r_phase <= TX_ADVANCE;
                                end
                            end
                        end
                        TX_ADVANCE: begin
                            r_phase <= TX_ISSUE;
                            r_state <= S_DUMP_ADDR;
                        end
                        default: r_phase <= TX_ISSUE;
                    endcase
                end
                S_DUMP_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DUMP_IDLE;
                end
                default: begin
                    r_state <= S_DUMP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_uart_dump.sv
// Directed bench for sram_uart_dump: SRAM model, UART line decoder and byte scoreboard.
module tb_sram_uart_dump;

    localparam int unsigned B = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [17:0] base = '0;
    logic [17:0] count = '0;
    logic [17:0] sram_addr;
    logic [15:0] rd_p1 = '0;
    logic        we_n;
    logic        uart_tx;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:262143];
    logic [7:0]  q [$];
    logic [17:0] alog [$];

    int checks = 0;
    int errors = 0;
    int pcount = 0;
    int e0 = 0;
    int first_fall = -1;
    int nframes = 0;
    int low_samples = 0;

    always #5 clk = ~clk;

    always @(posedge clk) pcount <= pcount + 1;

    // SRAM read data appears two cycles after the address is presented
    always @(posedge clk) rd_p1 <= mem[sram_addr];

    sram_uart_dump #(
        .BAUD_DIV (B),
        .ADDR_W   (18)
    ) dut (
        .Clock_50       (clk),
        .Resetn         (rst_n),
        .Start          (start),
        .Base_address   (base),
        .Word_count     (count),
        .SRAM_address   (sram_addr),
        .SRAM_read_data (rd_p1),
        .SRAM_we_n      (we_n),
        .UART_TX_O      (uart_tx),
        .Busy           (busy),
        .Done           (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a Start pulse and queue the bytes the dump must produce
    task automatic start_dump(input logic [17:0] b, input logic [17:0] n);
        logic [17:0] a;
        logic [15:0] w;
        @(negedge clk);
        base  = b;
        count = n;
        start = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 18'(i);
            w = mem[a];
            q.push_back(w[15:8]);
            q.push_back(w[7:0]);
        end
        alog.delete();
        first_fall = -1;
        @(negedge clk);
        e0 = pcount;
        start = 1'b0;
    endtask

    // Called at the cycle-1 negedge; runs until Done or the cycle budget expires
    task automatic wait_done(input int limit, input int restart_at,
                             output int done_cyc, output int busy_hi);
        done_cyc = -1;
        busy_hi  = 0;
        for (int k = 1; k <= limit; k++) begin
            if (busy === 1'b1) begin
                busy_hi++;
                if (alog.size() == 0 || alog[$] !== sram_addr) alog.push_back(sram_addr);
            end
            if (k == restart_at) begin
                start = 1'b1;
                base  = '0;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Line decoder: every bit must hold for exactly B cycles; bytes are popped from the scoreboard
    initial begin : decoder
        int       dcnt;
        int       bi;
        logic     dact;
        logic     bad;
        logic [9:0] bits;
        dcnt = 0;
        bi   = 0;
        dact = 1'b0;
        bad  = 1'b0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dact = 1'b0;
            end else begin
                if (uart_tx === 1'b0) low_samples++;
                if (!dact && uart_tx === 1'b0) begin
                    dact = 1'b1;
                    dcnt = 0;
                    bad  = 1'b0;
                    bits = '0;
                    if (first_fall < 0) first_fall = pcount - e0 + 1;
                end else if (dact) begin
                    dcnt++;
                end
                if (dact) begin
                    bi = dcnt / B;
                    if (dcnt % B == 0) bits[bi] = uart_tx;
                    else if (uart_tx !== bits[bi]) bad = 1'b1;
                    if (dcnt == 10 * B - 1) begin
                        chk("frame_start_stop_width", {29'd0, bad, bits[0], bits[9]}, 32'h1);
                        chk("byte_expected", (q.size() > 0), 1);
                        if (q.size() > 0) chk("byte_value", bits[8:1], q.pop_front());
                        nframes++;
                        dact = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int bh;
        int n0;
        int l0;

        for (int i = 0; i < 262144; i++) mem[i] = 16'(i) ^ 16'h5A3C;
        mem[100]      = 16'hA55A;
        mem[18'h3FFFF] = 16'h1234;
        mem[0]        = 16'hABCD;
        mem[200]      = 16'hC001;
        mem[201]      = 16'h0FF0;
        mem[202]      = 16'h1E2D;
        mem[300]      = 16'h00FF;
        mem[301]      = 16'h1111;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_we_n", we_n, 1);
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // One word 0xA55A at 100
        n0 = nframes;
        start_dump(18'd100, 18'd1);
        chk("A_busy_c1", busy, 1);
        chk("A_addr_c1", sram_addr, 100);
        wait_done(200, 0, dc, bh);
        chk("A_done_cycle", dc, 87);
        chk("A_busy_cycles", bh, 86);
        chk("A_first_fall", first_fall, 5);
        chk("A_addr_log_len", alog.size(), 1);
        chk("A_addr_log0", alog[0], 100);
        chk("A_frames", nframes - n0, 2);
        chk("A_queue_empty", q.size(), 0);
        @(negedge clk);
        chk("A_done_pulse_1cyc", done, 0);
        chk("A_busy_after", busy, 0);

        // Zero-length dump
        n0 = nframes;
        l0 = low_samples;
        start_dump(18'd555, 18'd0);
        wait_done(20, 0, dc, bh);
        chk("B_done_cycle", dc, 2);
        chk("B_busy_never", bh, 0);
        repeat (5) @(negedge clk);
        chk("B_no_line_low", low_samples - l0, 0);
        chk("B_frames", nframes - n0, 0);
        chk("B_addr_unchanged", sram_addr, 100);

        // Address wrap
        n0 = nframes;
        start_dump(18'h3FFFF, 18'd2);
        wait_done(400, 0, dc, bh);
        chk("C_done_cycle", dc, 173);
        chk("C_addr_log_len", alog.size(), 2);
        chk("C_addr_log0", alog[0], 18'h3FFFF);
        chk("C_addr_log1", alog[1], 0);
        chk("C_frames", nframes - n0, 4);
        chk("C_queue_empty", q.size(), 0);
        repeat (3) @(negedge clk);

        // Start during a busy 3-word dump is ignored
        n0 = nframes;
        start_dump(18'd200, 18'd3);
        wait_done(600, 20, dc, bh);
        chk("D_done_cycle", dc, 259);
        chk("D_frames", nframes - n0, 6);
        chk("D_queue_empty", q.size(), 0);
        chk("D_addr_log_len", alog.size(), 3);
        chk("D_addr_log2", alog[2], 202);
        repeat (3) @(negedge clk);

        // Reset during bit 4 of the first frame
        n0 = nframes;
        start_dump(18'd300, 18'd2);
        repeat (21) @(negedge clk);
        chk("E_busy_mid", busy, 1);
        chk("E_line_bit4", uart_tx, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("E_tx_async", uart_tx, 1);
        chk("E_busy_async", busy, 0);
        chk("E_done_async", done, 0);
        chk("E_addr_async", sram_addr, 0);
        q.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("E_aborted_frame_uncounted", nframes - n0, 0);
        n0 = nframes;
        start_dump(18'd100, 18'd1);
        wait_done(200, 0, dc, bh);
        chk("E_redump_done_cycle", dc, 87);
        chk("E_redump_first_fall", first_fall, 5);
        chk("E_redump_frames", nframes - n0, 2);
        chk("E_redump_queue_empty", q.size(), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_uart_dump.md
# sram_uart_dump

Streams a block of 16-bit words from external SRAM out of the board's UART TX pin, high byte first, as 8N1 frames. It is the transmit-direction counterpart of the UART-to-SRAM receive path used to load images. It lets the decoded RGB frame, or any SRAM region, be read back to the host PC for comparison against the software model. It sits beside the top-level FSM, shares the SRAM port through the existing top-level mux, and is started from the top-level state machine.

## Interface
Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); benches use 4.
- ADDR_W, 18, SRAM word-address width.

Ports:
- Clock_50  input  1  system clock, 50 MHz.
- Resetn  input  1  reset, asynchronous, active-low.
- Start  input  1  one-cycle request; sampled only in S_DUMP_IDLE.
- Base_address  input  ADDR_W  first word address; latched on accepted Start.
- Word_count  input  ADDR_W  number of words; latched on accepted Start.
- SRAM_address  output  ADDR_W  read address; reset 0.
- SRAM_read_data  input  16  SRAM controller read data, valid 2 cycles after address.
- SRAM_we_n  output  1  tied high (read-only); reset 1.
- UART_TX_O  output  1  serial line, idle high; reset 1.
- Busy  output  1  high from the cycle after an accepted Start until Done; reset 0.
- Done  output  1  one-cycle pulse when the dump completes; reset 0.

## Operation
- The FSM uses states S_DUMP_IDLE, S_DUMP_ADDR, S_DUMP_WAIT1, S_DUMP_WAIT2, S_DUMP_TX_HI, S_DUMP_TX_LO and S_DUMP_DONE.
- S_DUMP_IDLE:
  - On Start, latch Base_address into addr and Word_count into remaining.
  - If remaining is 0, go to S_DUMP_DONE; otherwise go to S_DUMP_ADDR.
- S_DUMP_ADDR: drive SRAM_address = addr, then go to S_DUMP_WAIT1.
- S_DUMP_WAIT1: go to S_DUMP_WAIT2.
- S_DUMP_WAIT2: latch SRAM_read_data into word_buf, then go to S_DUMP_TX_HI.
- S_DUMP_TX_HI:
  - Pulse Tx_start with word_buf[15:8].
  - Wait for the byte transmitter to return idle, then go to S_DUMP_TX_LO.
- S_DUMP_TX_LO:
  - Do the same with word_buf[7:0].
  - On the transmitter returning idle, decrement remaining and increment addr modulo 2^ADDR_W.
  - Go to S_DUMP_ADDR if remaining is non-zero, else S_DUMP_DONE.
- S_DUMP_DONE: pulse Done, clear Busy, return to S_DUMP_IDLE.
- Frame format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly BAUD_DIV cycles.
- Boundary behaviour:
  - Start while Busy is ignored. The latched parameters do not change.
  - Address wrap: 2^ADDR_W−1 is followed by 0.
  - Word_count = 0: no SRAM read and no line activity. Done pulses 2 cycles after Start.
  - Reset mid-frame: UART_TX_O goes high asynchronously, the FSM returns to S_DUMP_IDLE, and Busy and Done go to 0. No partial byte resumes.

## Timing
- Cycle 0 is the Start-sampling edge.
- Busy = 1 from cycle 1.
- SRAM_address is valid from cycle 1 and is held until the data is latched at cycle 3.
- Tx_start is issued at cycle 4. UART_TX_O falls (start bit) at cycle 5.
- Each byte frame is 10·BAUD_DIV cycles.
- The transmitter signals idle on the last cycle of the stop bit. The next Tx_start follows 1 cycle later, so there is a 1-cycle high gap between the hi and lo frames.
- Word period is exactly 20·BAUD_DIV + 6 cycles.
- For N ≥ 1 words, Done pulses at cycle N·(20·BAUD_DIV + 6) + 1, and Busy falls in the same cycle.
- The SRAM address changes only in S_DUMP_ADDR. It is never changed while a read is in flight.

## Structure
- The shared package (alongside define_state.h) holds:
  - the dump_state_type enum;
  - the default BAUD_DIV constant, shared with the UART receiver's baud constant.
- One sub-module, uart_tx_byte:
  - Ports: Clock_50, Resetn, Tx_start, Tx_data[7:0], UART_TX_O, Tx_busy.
  - Contents: bit counter (0–9), baud counter (0..BAUD_DIV−1), shift register.
  - Tx_start is ignored while Tx_busy is high.
- The top level adds the dump states to its state machine and muxes SRAM_address between the dump block and the other SRAM masters.

## Test plan
- BAUD_DIV=4, SRAM[100]=16'hA55A, Base=100, Count=1:
  - Line carries byte 0xA5 then 0x5A, each as 0,LSB..MSB,1, with 4 cycles per bit.
  - Done pulses at cycle 87.
- Count=0: no line transition and SRAM_address unchanged. Done at cycle 2, and Busy is never high.
- Base=18'h3FFFF, Count=2, SRAM[3FFFF]=16'h1234, SRAM[0]=16'hABCD:
  - Bytes 12 34 AB CD are sent in order.
  - SRAM_address sequence is 3FFFF then 00000.
- Start pulsed again at cycle 20 with Base=0 during a 3-word dump:
  - The request is ignored and exactly 6 bytes are sent.
  - Done pulses at cycle 259.
- Resetn dropped during bit 4 of the first frame:
  - UART_TX_O = 1 and Busy = 0 immediately.
  - After release, a new Start produces a clean full dump.
- Loopback: route UART_TX_O into the existing UART receiver and dump 76800 words. The received words equal the SRAM contents with zero mismatches.
